// File: rtl/learning_switch_opl.sv
// Output-port lookup: learns src MAC -> src port, CAM-looks-up dst MAC, writes dst oqs into tuser[31:24].
// Latency 1 cycle via one output register; s_axis_tready = !m_axis_tvalid | m_axis_tready, so stalls propagate with no bubble.
module learning_switch_opl #(
    parameter int         DATA_WIDTH  = 64,
    parameter int         TUSER_WIDTH = 128,
    parameter int         LUT_DEPTH   = 16,
    parameter logic [7:0] DEFAULT_OQS = 8'h55
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]  m_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    input  logic                    table_clear,
    output logic [31:0]             stat_hit,
    output logic [31:0]             stat_miss,
    output logic [6:0]              table_used
);
    localparam int IW   = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
    localparam bit WIDE = (DATA_WIDTH >= 128);

    typedef enum logic [1:0] {SOP, HDR2, BODY} state_t;
    state_t state, state_nxt;

    logic                   run;
    logic                   accept;
    logic [47:0]            dst_mac;
    logic [47:0]            src_mac;
    logic [7:0]             src_port;
    logic [7:0]             learn_port;
    logic                   learn_beat;
    logic                   learn_en;
    logic                   port_onehot;

    logic [LUT_DEPTH-1:0]   tbl_vld;
    logic [47:0]            tbl_mac  [LUT_DEPTH];
    logic [7:0]             tbl_port [LUT_DEPTH];
    logic [IW-1:0]          rptr;

    logic                   dst_hit;
    logic [7:0]             dst_port;
    logic                   src_hit;
    logic                   free_found;
    logic [IW-1:0]          src_idx;
    logic [IW-1:0]          free_idx;
    logic [IW-1:0]          wr_idx;
    logic                   is_flood;
    logic [TUSER_WIDTH-1:0] tuser_nxt;

    assign s_axis_tready = run & (~m_axis_tvalid | m_axis_tready);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign dst_mac       = s_axis_tdata[47:0];
    assign src_port      = s_axis_tuser[23:16];

    generate
        if (WIDE) begin : g_wide
            assign src_mac    = s_axis_tdata[95:48];
            assign learn_port = src_port;
            assign learn_beat = (state == SOP);
        end else begin : g_narrow
            // Low 16 bits of src and the ingress port are held from beat 0 until beat 1 completes src.
            logic [15:0] src_lo_q;
            logic [7:0]  port_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    src_lo_q <= '0;
                    port_q   <= '0;
                end else if (accept && state == SOP) begin
                    src_lo_q <= s_axis_tdata[63:48];
                    port_q   <= src_port;
                end
            end
            assign src_mac    = {s_axis_tdata[31:0], src_lo_q};
            assign learn_port = port_q;
            assign learn_beat = (state == HDR2);
        end
    endgenerate

    assign port_onehot = (learn_port != 8'h00) && ((learn_port & (learn_port - 8'd1)) == 8'h00);
    assign learn_en    = accept & learn_beat & ~src_mac[0] & port_onehot & ~table_clear;

    always_comb begin
        dst_hit    = 1'b0;
        dst_port   = '0;
        src_hit    = 1'b0;
        src_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            if (tbl_vld[i] && tbl_mac[i] == dst_mac) begin
                dst_hit  = 1'b1;
                dst_port = tbl_port[i];
            end
            if (tbl_vld[i] && tbl_mac[i] == src_mac && !src_hit) begin
                src_hit = 1'b1;
                src_idx = IW'(i);
            end
            if (!tbl_vld[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    assign wr_idx   = src_hit ? src_idx : (free_found ? free_idx : rptr);
    assign is_flood = dst_mac[0] | ~dst_hit;

    always_comb begin
        tuser_nxt = s_axis_tuser;
        if (state == SOP) begin
            if (is_flood)
                tuser_nxt[31:24] = DEFAULT_OQS & ~src_port;
            else if (dst_port == src_port)
                tuser_nxt[31:24] = 8'h00;
            else
                tuser_nxt[31:24] = dst_port;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SOP;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (s_axis_tlast)       state_nxt = SOP;
            else if (state == SOP)  state_nxt = WIDE ? BODY : HDR2;
            else                    state_nxt = BODY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run           <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            stat_hit      <= '0;
            stat_miss     <= '0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tkeep  <= s_axis_tkeep;
                m_axis_tuser  <= tuser_nxt;
                m_axis_tlast  <= s_axis_tlast;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (accept && state == SOP) begin
                if (is_flood) begin
                    if (stat_miss != 32'hFFFF_FFFF) stat_miss <= stat_miss + 32'd1;
                end else if (stat_hit != 32'hFFFF_FFFF) begin
                    stat_hit <= stat_hit + 32'd1;
                end
            end
        end
    end

    // Clear has priority over any learn arriving in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tbl_vld    <= '0;
            rptr       <= '0;
            table_used <= '0;
        end else if (table_clear) begin
            tbl_vld    <= '0;
            rptr       <= '0;
            table_used <= '0;
        end else if (learn_en && !src_hit) begin
            tbl_vld[wr_idx] <= 1'b1;
            if (free_found)
                table_used <= table_used + 7'd1;
            else
                rptr <= (rptr == IW'(LUT_DEPTH - 1)) ? '0 : rptr + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (learn_en) begin
            tbl_mac[wr_idx]  <= src_mac;
            tbl_port[wr_idx] <= learn_port;
        end
    end
endmodule

// File: tb/tb_learning_switch_opl.sv
// Bench for learning_switch_opl: directed scenarios plus randomized traffic, scored against a
// behavioural table model and an expected-beat queue.
module tb_learning_switch_opl;
    localparam int          LUT_DEPTH   = 16;
    localparam logic [7:0]  DEFAULT_OQS = 8'h55;
    localparam logic [47:0] BCAST       = 48'hFFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [63:0]  s_axis_tdata;
    logic [7:0]   s_axis_tkeep;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [63:0]  m_axis_tdata;
    logic [7:0]   m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic         table_clear;
    logic [31:0]  stat_hit;
    logic [31:0]  stat_miss;
    logic [6:0]   table_used;

    always #5 clk = ~clk;

    learning_switch_opl #(
        .DATA_WIDTH(64), .TUSER_WIDTH(128), .LUT_DEPTH(LUT_DEPTH), .DEFAULT_OQS(DEFAULT_OQS)
    ) dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .table_clear(table_clear), .stat_hit(stat_hit), .stat_miss(stat_miss), .table_used(table_used)
    );

    typedef struct {
        logic [63:0]  d;
        logic [7:0]   k;
        logic [127:0] u;
        logic         l;
        bit           sop;
    } beat_t;

    beat_t      exp_q[$];
    int         n_pass = 0;
    int         n_total = 0;
    bit         rand_bp = 1'b0;
    bit         gaps = 1'b0;
    logic [7:0] last_sop_oqs = 8'h00;

    // Reference model: an associative table of MAC -> port with the documented insert/replace rules.
    bit          mdl_vld  [LUT_DEPTH];
    logic [47:0] mdl_mac  [LUT_DEPTH];
    logic [7:0]  mdl_port [LUT_DEPTH];
    int          mdl_ptr, mdl_used, mdl_hit, mdl_miss;

    function automatic void mdl_clear();
        for (int i = 0; i < LUT_DEPTH; i++) mdl_vld[i] = 1'b0;
        mdl_ptr  = 0;
        mdl_used = 0;
    endfunction

    function automatic void mdl_reset();
        mdl_clear();
        mdl_hit  = 0;
        mdl_miss = 0;
    endfunction

    function automatic logic [7:0] mdl_lookup(input logic [47:0] dst, input logic [7:0] sport);
        if (!dst[0]) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                if (mdl_vld[i] && mdl_mac[i] == dst) begin
                    mdl_hit++;
                    return (mdl_port[i] == sport) ? 8'h00 : mdl_port[i];
                end
            end
        end
        mdl_miss++;
        return DEFAULT_OQS & ~sport;
    endfunction

    function automatic void mdl_learn(input logic [47:0] src, input logic [7:0] port);
        if (src[0] || $countones(port) != 1) return;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            if (mdl_vld[i] && mdl_mac[i] == src) begin
                mdl_port[i] = port;
                return;
            end
        end
        for (int i = 0; i < LUT_DEPTH; i++) begin
            if (!mdl_vld[i]) begin
                mdl_vld[i] = 1'b1; mdl_mac[i] = src; mdl_port[i] = port;
                mdl_used++;
                return;
            end
        end
        mdl_mac[mdl_ptr]  = src;
        mdl_port[mdl_ptr] = port;
        mdl_ptr = (mdl_ptr + 1) % LUT_DEPTH;
    endfunction

    function automatic logic [47:0] mac(input logic [7:0] b0, b1, b2, b3, b4, b5);
        return {b5, b4, b3, b2, b1, b0};
    endfunction

    function automatic logic [47:0] wsrc(input int i);
        return {8'(i), 40'h00_0000_0002};
    endfunction

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_bp) m_axis_tready = ($urandom % 4) != 0;
        end
    end

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (reset && m_axis_tvalid && m_axis_tready) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_beat got tdata=%h with no beat expected", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (m_axis_tdata !== e.d || m_axis_tkeep !== e.k || m_axis_tuser !== e.u || m_axis_tlast !== e.l)
                        $display("FAIL beat got d=%h k=%h u=%h l=%b exp d=%h k=%h u=%h l=%b",
                                 m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, e.d, e.k, e.u, e.l);
                    else
                        n_pass++;
                    if (e.sop) last_sop_oqs = m_axis_tuser[31:24];
                end
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    task automatic send_pkt(input logic [47:0] dst, input logic [47:0] src, input logic [7:0] port,
                            input int nbeats, input int clr_beat);
        logic [63:0]  d;
        logic [7:0]   k;
        logic [127:0] u;
        beat_t        e;
        int           n;
        for (int b = 0; b < nbeats; b++) begin
            d = {$urandom, $urandom};
            k = 8'($urandom);
            u = {$urandom, $urandom, $urandom, $urandom};
            if (b == 0) begin
                d[47:0]  = dst;
                d[63:48] = src[15:0];
                u[23:16] = port;
            end
            if (b == 1) d[31:0] = src[47:16];
            if (gaps && ($urandom % 4) == 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_axis_tdata = d; s_axis_tkeep = k; s_axis_tuser = u;
            s_axis_tlast = (b == nbeats - 1); s_axis_tvalid = 1'b1;
            if (b == clr_beat) table_clear = 1'b1;
            n = 0;
            @(negedge clk);
            while (!s_axis_tready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!s_axis_tready) begin
                n_total++;
                $display("FAIL accept_timeout tready=%0b required 1", s_axis_tready);
            end
            e.d = d; e.k = k; e.u = u; e.l = (b == nbeats - 1); e.sop = (b == 0);
            if (b == 0) e.u[31:24] = mdl_lookup(dst, port);
            if (b == clr_beat) mdl_clear();
            else if (b == 1) mdl_learn(src, port);
            exp_q.push_back(e);
            @(posedge clk); #1;
            s_axis_tvalid = 1'b0;
            table_clear   = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (exp_q.size() != 0) $display("FAIL drain_timeout beats_left=%0d required 0", exp_q.size());
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        s_axis_tvalid = 1'b0;
        table_clear = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        mdl_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_total++; if (s_axis_tready !== 1'b0) $display("FAIL rst_tready got=%b exp=0", s_axis_tready); else n_pass++;
        n_total++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid got=%b exp=0", m_axis_tvalid); else n_pass++;
        n_total++; if (m_axis_tdata !== 64'd0 || m_axis_tuser !== 128'd0) $display("FAIL rst_data got=%h/%h exp=0", m_axis_tdata, m_axis_tuser); else n_pass++;
        n_total++; if (stat_hit !== 32'd0 || stat_miss !== 32'd0) $display("FAIL rst_stats got=%0d/%0d exp=0/0", stat_hit, stat_miss); else n_pass++;
        n_total++; if (table_used !== 7'd0) $display("FAIL rst_used got=%0d exp=0", table_used); else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
        n_total++; if (s_axis_tready !== 1'b1) $display("FAIL idle_tready got=%b exp=1", s_axis_tready); else n_pass++;
        n_total++; if (m_axis_tvalid !== 1'b0) $display("FAIL idle_tvalid got=%b exp=0", m_axis_tvalid); else n_pass++;
    endtask

    task automatic test_learn_hit();
        logic [47:0] mac_a;
        mac_a = mac(8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        apply_reset();
        send_pkt(BCAST, mac_a, 8'h01, 2, -1);
        drain();
        send_pkt(mac_a, mac(8'h00, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'h02), 8'h04, 3, -1);
        drain();
        n_total++; if (last_sop_oqs !== 8'h01) $display("FAIL hit_oqs got=%h exp=01", last_sop_oqs); else n_pass++;
        n_total++; if (stat_hit !== 32'd1) $display("FAIL hit_stat got=%0d exp=1", stat_hit); else n_pass++;
        n_total++; if (table_used !== 7'd2) $display("FAIL hit_used got=%0d exp=2", table_used); else n_pass++;
        send_pkt(mac_a, mac(8'h00, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'h03), 8'h01, 2, -1);
        drain();
        n_total++; if (last_sop_oqs !== 8'h00) $display("FAIL filter_oqs got=%h exp=00", last_sop_oqs); else n_pass++;
        n_total++; if (stat_hit !== 32'd2) $display("FAIL filter_stat got=%0d exp=2", stat_hit); else n_pass++;
    endtask

    task automatic test_miss_flood();
        apply_reset();
        send_pkt(BCAST, mac(8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05), 8'h04, 2, -1);
        drain();
        n_total++; if (last_sop_oqs !== 8'h51) $display("FAIL bcast_oqs got=%h exp=51", last_sop_oqs); else n_pass++;
        send_pkt(mac(8'h00, 8'hde, 8'had, 8'hbe, 8'hef, 8'h01), mac(8'h00, 8'h07, 8'h08, 8'h09, 8'h0a, 8'h0b), 8'h10, 2, -1);
        drain();
        n_total++; if (last_sop_oqs !== 8'h45) $display("FAIL unk_oqs got=%h exp=45", last_sop_oqs); else n_pass++;
        n_total++; if (stat_miss !== 32'd2) $display("FAIL miss_stat got=%0d exp=2", stat_miss); else n_pass++;
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i <= LUT_DEPTH; i++) send_pkt(BCAST, wsrc(i), 8'h01, 2, -1);
        drain();
        n_total++; if (table_used !== 7'(LUT_DEPTH)) $display("FAIL wrap_used got=%0d exp=%0d", table_used, LUT_DEPTH); else n_pass++;
        send_pkt(wsrc(0), wsrc(0), 8'h04, 1, -1);
        drain();
        n_total++; if (last_sop_oqs !== 8'h51) $display("FAIL wrap_evicted got=%h exp=51", last_sop_oqs); else n_pass++;
        send_pkt(wsrc(1), wsrc(0), 8'h04, 1, -1);
        drain();
        n_total++; if (last_sop_oqs !== 8'h01) $display("FAIL wrap_kept got=%h exp=01", last_sop_oqs); else n_pass++;
        send_pkt(wsrc(LUT_DEPTH), wsrc(0), 8'h04, 1, -1);
        drain();
        n_total++; if (last_sop_oqs !== 8'h01) $display("FAIL wrap_new got=%h exp=01", last_sop_oqs); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [63:0]  sd;
        logic [7:0]   sk;
        logic [127:0] su;
        logic         sl;
        rand_bp = 1'b0; gaps = 1'b0; m_axis_tready = 1'b1;
        fork
            send_pkt(BCAST, mac(8'h00, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25), 8'h40, 8, -1);
            begin
                repeat (3) @(posedge clk);
                #1 m_axis_tready = 1'b0;
                @(negedge clk);
                sd = m_axis_tdata; sk = m_axis_tkeep; su = m_axis_tuser; sl = m_axis_tlast;
                n_total++; if (m_axis_tvalid !== 1'b1) $display("FAIL bp_valid got=%b exp=1", m_axis_tvalid); else n_pass++;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    n_total++;
                    if ({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tvalid} !== {sd, sk, su, sl, 1'b1})
                        $display("FAIL bp_stable cycle=%0d got d=%h u=%h v=%b exp d=%h u=%h v=1", c, m_axis_tdata, m_axis_tuser, m_axis_tvalid, sd, su);
                    else n_pass++;
                    n_total++; if (s_axis_tready !== 1'b0) $display("FAIL bp_tready cycle=%0d got=%b exp=0", c, s_axis_tready); else n_pass++;
                end
                @(posedge clk);
                #1 m_axis_tready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_runt_clear_reset();
        logic [47:0] mac_r;
        mac_r = mac(8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35);
        apply_reset();
        rand_bp = 1'b0; gaps = 1'b0; m_axis_tready = 1'b1;
        send_pkt(BCAST, mac_r, 8'h01, 1, -1);
        drain();
        n_total++; if (table_used !== 7'd0) $display("FAIL runt_used got=%0d exp=0", table_used); else n_pass++;
        send_pkt(mac_r, mac(8'h00, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45), 8'h04, 2, -1);
        drain();
        n_total++; if (last_sop_oqs !== 8'h51) $display("FAIL runt_lookup got=%h exp=51", last_sop_oqs); else n_pass++;
        n_total++; if (table_used !== 7'd1) $display("FAIL learn_used got=%0d exp=1", table_used); else n_pass++;
        table_clear = 1'b1;
        @(posedge clk); #1;
        table_clear = 1'b0;
        mdl_clear();
        n_total++; if (table_used !== 7'd0) $display("FAIL clear_used got=%0d exp=0", table_used); else n_pass++;
        send_pkt(BCAST, mac(8'h00, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55), 8'h10, 2, 1);
        drain();
        n_total++; if (table_used !== 7'd0) $display("FAIL clear_vs_learn got=%0d exp=0", table_used); else n_pass++;
        // Reset mid-packet: beat 0 is parked in the output register when reset hits.
        m_axis_tready = 1'b0;
        s_axis_tdata = {$urandom, $urandom}; s_axis_tkeep = 8'hFF; s_axis_tuser = {4{$urandom}};
        s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        @(posedge clk); #1;
        s_axis_tdata = {$urandom, $urandom};
        @(negedge clk);
        n_total++; if (m_axis_tvalid !== 1'b1) $display("FAIL pre_rst_valid got=%b exp=1", m_axis_tvalid); else n_pass++;
        #1 reset = 1'b0;
        #1;
        n_total++; if (m_axis_tvalid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", m_axis_tvalid); else n_pass++;
        n_total++; if (s_axis_tready !== 1'b0 || m_axis_tdata !== 64'd0) $display("FAIL midrst_out got rdy=%b d=%h exp 0/0", s_axis_tready, m_axis_tdata); else n_pass++;
        s_axis_tvalid = 1'b0;
        exp_q.delete();
        mdl_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        send_pkt(BCAST, mac(8'h00, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65), 8'h04, 2, -1);
        drain();
        n_total++; if (last_sop_oqs !== 8'h51) $display("FAIL post_rst_oqs got=%h exp=51", last_sop_oqs); else n_pass++;
        n_total++; if (table_used !== 7'd1) $display("FAIL post_rst_used got=%0d exp=1", table_used); else n_pass++;
    endtask

    task automatic test_random();
        logic [47:0] pool [20];
        logic [7:0]  ports [4];
        logic [47:0] dst;
        logic [7:0]  port;
        ports[0] = 8'h01; ports[1] = 8'h04; ports[2] = 8'h10; ports[3] = 8'h40;
        for (int i = 0; i < 20; i++) begin
            pool[i] = {16'($urandom), $urandom};
            pool[i][0] = 1'b0;
        end
        pool[19][0] = 1'b1;
        apply_reset();
        rand_bp = 1'b1; gaps = 1'b1;
        for (int p = 0; p < 120; p++) begin
            port = ($urandom % 10 == 0) ? 8'h05 : ports[$urandom % 4];
            dst  = ($urandom % 8 == 0) ? BCAST : pool[$urandom % 20];
            send_pkt(dst, pool[$urandom % 20], port, 1 + int'($urandom % 5), -1);
        end
        drain();
        rand_bp = 1'b0; gaps = 1'b0; m_axis_tready = 1'b1;
        n_total++; if (stat_hit !== 32'(mdl_hit)) $display("FAIL rnd_hit got=%0d exp=%0d", stat_hit, mdl_hit); else n_pass++;
        n_total++; if (stat_miss !== 32'(mdl_miss)) $display("FAIL rnd_miss got=%0d exp=%0d", stat_miss, mdl_miss); else n_pass++;
        n_total++; if (table_used !== 7'(mdl_used)) $display("FAIL rnd_used got=%0d exp=%0d", table_used, mdl_used); else n_pass++;
    endtask

    initial begin
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        table_clear = 1'b0; m_axis_tready = 1'b1;
        mdl_reset();
        test_reset();
        test_learn_hit();
        test_miss_flood();
        test_wrap();
        test_backpressure();
        test_runt_clear_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
